spi_burst_ref_model: RTL and testbench

SPI_BURST_REF_MODEL -- requirements
Module: spi_burst_ref_model

---
 rtl/shared_pkg.sv | 20 ++
 rtl/spi_miso_delay.sv | 37 +++
 rtl/spi_burst_ref_model.sv | 171 +++++++++++++++++
 tb/tb_spi_burst_ref_model.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types for the SPI burst reference model.
// Command and state encodings plus the slave-select level.
package shared_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        READ = 2'd2
    } state_e;

    localparam logic SLAVE_SELECTED = 1'b0;

endpackage

// File: rtl/spi_miso_delay.sv
// Fixed-depth delay line aligning the reference MISO bit.
// DEPTH = 0 degenerates to a wire.
module spi_miso_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused;
        assign unused = clk ^ rst_n;
        assign dout   = din;
    end else begin : g_pipe
        logic [DEPTH-1:0] pipe_q;
        logic [DEPTH-1:0] pipe_d;

        // Shift one stage per cycle, independent of slave select.
        always_comb begin
            pipe_d = (pipe_q << 1) | DEPTH'(din);
        end

        // Pipeline register, cleared asynchronously.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign dout = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/spi_burst_ref_model.sv
// Cycle-accurate SPI slave reference: frame decoder, word memory and MISO model.
// Burst reads and auto-increment writes are enabled by SPI_REF_BURST_EN.
module spi_burst_ref_model
    import shared_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_SIZE  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MISO_DELAY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO_ref,
    output logic rd_active,
    output logic addr_err
);

    localparam int FRAME_W = DATA_WIDTH + 2;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int RD_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [ADDR_SIZE:0]   DEPTH_W  = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [RD_W-1:0]      LAST_RD  = RD_W'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [FRAME_W-2:0]      shift_q, shift_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [RD_W-1:0]         rd_cnt_q, rd_cnt_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   rd_word_q, rd_word_d;
    logic                    addr_err_q, addr_err_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    mem_we;

    logic [FRAME_W-1:0]      frame;
    cmd_e                    cmd;
    logic [DATA_WIDTH-1:0]   payload;
    logic                    addr_ok;
    logic [DATA_WIDTH-1:0]   rd_mem;
    logic                    miso_core;

    // The last frame bit comes straight from MOSI on the decode edge.
    assign frame   = {shift_q, MOSI};
    assign cmd     = cmd_e'(frame[FRAME_W-1 -: 2]);
    assign payload = frame[DATA_WIDTH-1:0];
    assign addr_ok = {1'b0, addr_q} < DEPTH_W;
    assign rd_mem  = addr_ok ? mem[addr_q] : '0;

`ifdef SPI_REF_BURST_EN
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [ADDR_SIZE-1:0]    next_addr;
    logic                    next_ok;
    logic [DATA_WIDTH-1:0]   next_mem;

    assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_SIZE'(1);
    assign next_ok   = {1'b0, next_addr} < DEPTH_W;
    assign next_mem  = next_ok ? mem[next_addr] : '0;
`endif

    // Next-state, frame decode and read sequencing.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        addr_d     = addr_q;
        rd_word_d  = rd_word_q;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        if (SS_n != SLAVE_SELECTED) begin
            state_d   = IDLE;
            shift_d   = '0;
            bit_cnt_d = '0;
            rd_cnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, CMD: begin
                    state_d = CMD;
                    shift_d = frame[FRAME_W-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        unique case (cmd)
                            WR_ADDR, RD_ADDR: begin
                                addr_d = payload[ADDR_SIZE-1:0];
                            end
                            WR_DATA: begin
                                mem_we     = addr_ok;
                                addr_err_d = !addr_ok;
`ifdef SPI_REF_BURST_EN
                                addr_d     = next_addr;
`endif
                            end
                            RD_DATA: begin
                                rd_word_d  = rd_mem;
                                addr_err_d = !addr_ok;
                                rd_cnt_d   = '0;
                                state_d    = READ;
                            end
                            default: ;
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                READ: begin
                    if (rd_cnt_q == LAST_RD) begin
                        rd_cnt_d = '0;
`ifdef SPI_REF_BURST_EN
                        addr_d     = next_addr;
                        rd_word_d  = next_mem;
                        addr_err_d = !next_ok;
`else
                        state_d    = CMD;
                        bit_cnt_d  = '0;
`endif
                    end else begin
                        rd_cnt_d = rd_cnt_q + RD_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            addr_q     <= '0;
            rd_word_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            addr_q     <= addr_d;
            rd_word_q  <= rd_word_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Word memory; deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= payload;
        end
    end

    assign miso_core = (state_q == READ) ? rd_word_q[LAST_RD - rd_cnt_q] : 1'b0;
    assign rd_active = (state_q == READ);
    assign addr_err  = addr_err_q;

    spi_miso_delay #(
        .DEPTH (MISO_DELAY)
    ) u_miso_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (miso_core),
        .dout  (MISO_ref)
    );

endmodule

// File: tb/tb_spi_burst_ref_model.sv
// Scoreboard bench for spi_burst_ref_model (two depths, shared stimulus driver).
// Expected bits come from a transaction-level model of memory and address.
module tb_spi_burst_ref_model;

    localparam int D = 2;
`ifdef SPI_REF_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ss    = 1'b1;
    logic mosi  = 1'b0;
    bit   sel   = 1'b0;

    logic ss0, ss1;
    logic miso0, miso1, ra0, ra1, er0, er1;

    assign ss0 = sel ? 1'b1 : ss;
    assign ss1 = sel ? ss : 1'b1;

    spi_burst_ref_model #(
        .MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_WIDTH(8), .MISO_DELAY(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(ss0), .MOSI(mosi),
        .MISO_ref(miso0), .rd_active(ra0), .addr_err(er0)
    );

    spi_burst_ref_model #(
        .MEM_DEPTH(200), .ADDR_SIZE(8), .DATA_WIDTH(8), .MISO_DELAY(D)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .SS_n(ss1), .MOSI(mosi),
        .MISO_ref(miso1), .rd_active(ra1), .addr_err(er1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_c = 0;

    typedef struct {
        int   c;
        logic v;
    } exp_t;

    exp_t mq[$];
    int   rq[$];
    int   eq[$];

    logic [7:0] m_mem [2][256];
    logic [7:0] m_addr [2];
    int         depth [2] = '{256, 200};

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] inc(logic [7:0] a);
        return (int'(a) == depth[sel] - 1) ? 8'h00 : a + 8'h01;
    endfunction

    // Monitor: every cycle, compare outputs with what the scoreboard expects.
    logic e_m, e_r, e_e;
    always @(negedge clk) begin
        #1;
        e_m = 1'b0;
        e_r = 1'b0;
        e_e = 1'b0;
        while (mq.size() > 0 && mq[0].c < cyc) begin
            checks++; errors++;
            $display("FAIL stale_miso cyc=%0d got=none exp=%0d", cyc, mq[0].c);
            void'(mq.pop_front());
        end
        if (mq.size() > 0 && mq[0].c == cyc) begin
            e_m = mq[0].v;
            void'(mq.pop_front());
        end
        if (rq.size() > 0 && rq[0] == cyc) begin
            e_r = 1'b1;
            void'(rq.pop_front());
        end
        if (eq.size() > 0 && eq[0] == cyc) begin
            e_e = 1'b1;
            void'(eq.pop_front());
        end
        check("miso_ref", sel ? miso1 : miso0, e_m);
        check("rd_active", sel ? ra1 : ra0, e_r);
        check("addr_err", sel ? er1 : er0, e_e);
    end

    task automatic drive(logic s, logic m);
        @(negedge clk);
        ss     = s;
        mosi   = m;
        last_c = cyc;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b1, 1'($urandom));
    endtask

    task automatic model_read(int c, output logic [7:0] w);
        if (int'(m_addr[sel]) < depth[sel]) begin
            w = m_mem[sel][m_addr[sel]];
        end else begin
            w = 8'h00;
            eq.push_back(c);
        end
    endtask

    task automatic send_frame(logic [1:0] cmd, logic [7:0] pl, int nbits = 10);
        logic [9:0] f;
        f = {cmd, pl};
        for (int i = 9; i >= 10 - nbits; i--) drive(1'b0, f[i]);
        if (nbits == 10) begin
            case (cmd)
                2'b00, 2'b10: m_addr[sel] = pl;
                2'b01: begin
                    if (int'(m_addr[sel]) < depth[sel]) m_mem[sel][m_addr[sel]] = pl;
                    else eq.push_back(last_c + 1);
                    if (BURST) m_addr[sel] = inc(m_addr[sel]);
                end
                default: ;
            endcase
        end
    endtask

    task automatic rd_data(int n, bit desel);
        logic [7:0] w;
        int c;
        send_frame(2'b11, 8'($urandom));
        model_read(last_c + 1, w);
        for (int k = 0; k < n; k++) begin
            drive(desel && (k == n - 1), 1'($urandom));
            c = last_c;
            mq.push_back('{c + D, w[7 - (k % 8)]});
            rq.push_back(c);
            if (ss) break;
            if (k % 8 == 7) begin
                if (!BURST) break;
                m_addr[sel] = inc(m_addr[sel]);
                model_read(c + 1, w);
            end
        end
    endtask

    task automatic mid_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_miso_ref", sel ? miso1 : miso0, 1'b0);
        check("rst_rd_active", sel ? ra1 : ra0, 1'b0);
        check("rst_addr_err", sel ? er1 : er0, 1'b0);
        mq.delete();
        rq.delete();
        eq.delete();
        m_addr[0] = 8'h00;
        m_addr[1] = 8'h00;
        ss = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        m_addr[0] = 8'h00;
        m_addr[1] = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int a = 0; a < 256; a++) begin
            send_frame(2'b00, 8'(a));
            send_frame(2'b01, 8'($urandom));
        end
        idle(2);

        send_frame(2'b00, 8'h05);
        send_frame(2'b01, 8'hA5);
        send_frame(2'b10, 8'h05);
        rd_data(8, BURST);
        idle(3);

`ifdef SPI_REF_BURST_EN
        send_frame(2'b00, 8'hFE);
        send_frame(2'b01, 8'h11);
        send_frame(2'b01, 8'h22);
        send_frame(2'b01, 8'h33);
        send_frame(2'b10, 8'hFE);
        rd_data(24, 1'b1);
        idle(2);
        rd_data(8, 1'b1);
        idle(2);
`endif

        send_frame(2'b00, 8'h40);
        send_frame(2'b01, 8'h81);
        send_frame(2'b00, 8'h40);
        send_frame(2'b01, 8'h7E, 5);
        idle(1);
        send_frame(2'b10, 8'h40);
        rd_data(8, BURST);
        idle(D + 3);

        sel = 1'b1;
        send_frame(2'b00, 8'hF0);
        send_frame(2'b01, 8'h12);
        send_frame(2'b10, 8'hF0);
        rd_data(8, 1'b1);
        idle(D + 3);
        sel = 1'b0;

        send_frame(2'b10, 8'h05);
        rd_data(3, 1'b0);
        mid_reset();
        idle(2);
        send_frame(2'b10, 8'h05);
        rd_data(8, BURST);
        idle(2);

`ifndef SPI_REF_BURST_EN
        send_frame(2'b10, 8'h05);
        rd_data(8, 1'b0);
        send_frame(2'b00, 8'h60);
        send_frame(2'b01, 8'h3C);
        send_frame(2'b10, 8'h60);
        rd_data(8, 1'b0);
        idle(2);
`endif

        repeat (80) begin
            case ($urandom_range(0, 4))
                0: send_frame(2'b00, 8'($urandom));
                1: send_frame(2'b01, 8'($urandom));
                2: send_frame(2'b10, 8'($urandom));
                3: begin
                    if (BURST) rd_data(8 * $urandom_range(1, 3), 1'b1);
                    else rd_data(8, 1'($urandom));
                end
                default: idle($urandom_range(1, 3));
            endcase
        end

        idle(D + 4);
        checks++;
        if (mq.size() + rq.size() + eq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", mq.size() + rq.size() + eq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
